// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply and restoring divide
// on operand magnitudes, with a final sign-fixup cycle and single-cycle MTHI/MTLO.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam int unsigned PW = 2 * WIDTH;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t            state, state_n;
  logic [CW-1:0]     count, count_n;
  logic [PW-1:0]     prod, prod_n;
  logic [WIDTH-1:0]  opnd_b, opnd_b_n;
  logic              sign_a, sign_a_n;
  logic              neg, neg_n;
  logic              is_div, is_div_n;
  logic              busy_n, done_n;
  logic [WIDTH-1:0]  hi_n, lo_n;

  logic              signed_op, sa, sb;
  logic [WIDTH-1:0]  mag_a, mag_b;
  logic [WIDTH:0]    add_sum;
  logic [WIDTH:0]    shifted;
  logic              q_bit;
  logic [WIDTH-1:0]  rem_new;
  logic [PW-1:0]     prod_signed;
  logic [WIDTH-1:0]  quo, rem;

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      count  <= '0;
      prod   <= '0;
      opnd_b <= '0;
      sign_a <= 1'b0;
      neg    <= 1'b0;
      is_div <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      state  <= state_n;
      count  <= count_n;
      prod   <= prod_n;
      opnd_b <= opnd_b_n;
      sign_a <= sign_a_n;
      neg    <= neg_n;
      is_div <= is_div_n;
      busy   <= busy_n;
      done   <= done_n;
      hi     <= hi_n;
      lo     <= lo_n;
    end
  end

  // Next-state, iteration datapath and HI/LO write-back
  always_comb begin
    state_n  = state;
    count_n  = count;
    prod_n   = prod;
    opnd_b_n = opnd_b;
    sign_a_n = sign_a;
    neg_n    = neg;
    is_div_n = is_div;
    busy_n   = busy;
    done_n   = 1'b0;
    hi_n     = hi;
    lo_n     = lo;

    signed_op = (op == OP_MULT) || (op == OP_DIV);
    sa        = signed_op & rs[WIDTH-1];
    sb        = signed_op & rt[WIDTH-1];
    mag_a     = sa ? -rs : rs;
    mag_b     = sb ? -rt : rt;

    add_sum   = {1'b0, prod[PW-1:WIDTH]} + {1'b0, (prod[0] ? opnd_b : '0)};
    shifted   = prod[PW-1:WIDTH-1];
    q_bit     = (shifted >= {1'b0, opnd_b});
    rem_new   = q_bit ? WIDTH'(shifted - {1'b0, opnd_b}) : shifted[WIDTH-1:0];

    prod_signed = neg ? -prod : prod;
    quo         = neg ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
    rem         = sign_a ? -prod[PW-1:WIDTH] : prod[PW-1:WIDTH];

    case (state)
      IDLE: begin
        if (start) begin
          if (op <= OP_DIVU) begin
            state_n  = RUN;
            count_n  = '0;
            prod_n   = {{WIDTH{1'b0}}, mag_a};
            opnd_b_n = mag_b;
            sign_a_n = sa;
            neg_n    = sa ^ sb;
            is_div_n = op[1];
            busy_n   = 1'b1;
          end else if (op == OP_MTHI) begin
            hi_n = rs;
          end else if (op == OP_MTLO) begin
            lo_n = rs;
          end
        end
      end
      RUN: begin
        // Multiply shifts product right; divide shifts remainder:quotient left
        if (is_div) prod_n = {rem_new, prod[WIDTH-2:0], q_bit};
        else        prod_n = {add_sum, prod[WIDTH-1:1]};
        count_n = count + CW'(1);
        if (count == CW'(WIDTH - 1)) state_n = FIX;
      end
      FIX: begin
        state_n = IDLE;
        busy_n  = 1'b0;
        done_n  = 1'b1;
        if (is_div) begin
          // Zero divisor leaves |rs| as remainder, so hi naturally equals rs
          lo_n = (opnd_b == '0) ? '1 : quo;
          hi_n = rem;
        end else begin
          {hi_n, lo_n} = prod_signed;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, corner-case
// sequences and randomized ops against an arithmetic reference model.
module tb_mult_div_unit;

  localparam int unsigned W = 32;

  logic         clk;
  logic         reset;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] rs, rt;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] hi_m = '0;
  logic [W-1:0] lo_m = '0;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] rs;
    logic [W-1:0] rt;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  vec_t vecs[6];

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs(rs), .rt(rt),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Architectural result of one operation: {hi, lo}
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] h,
                                        input logic [31:0] l);
    longint sa, sb, sq, sr;
    logic [63:0] p;
    logic [31:0] uq, ur;
    case (o)
      3'd0: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p = 64'(sa * sb);
        return p;
      end
      3'd1: return {32'd0, a} * {32'd0, b};
      3'd2: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sq = sa / sb;
        sr = sa % sb;
        return {sr[31:0], sq[31:0]};
      end
      3'd3: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        uq = a / b;
        ur = a % b;
        return {ur, uq};
      end
      3'd4: return {a, l};
      3'd5: return {h, a};
      default: return {h, l};
    endcase
  endfunction

  task automatic launch(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; rs = a; rt = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int edges, output int busy_cnt);
    edges = 0;
    busy_cnt = 0;
    while (!done && edges < 60) begin
      if (busy) busy_cnt++;
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic run_long(input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input string name);
    logic [63:0] exp;
    int edges, bc;
    exp = model(o, a, b, hi_m, lo_m);
    launch(o, a, b);
    wait_done(edges, bc);
    check({name, "_latency"}, 64'(edges), 64'(W + 1));
    check({name, "_busy_cycles"}, 64'(bc), 64'(W + 1));
    check({name, "_busy_low_at_done"}, 64'(busy), 64'(0));
    check({name, "_hilo"}, {hi, lo}, exp);
    {hi_m, lo_m} = exp;
  endtask

  initial begin
    int edges, bc, done_seen;
    logic [2:0] o;
    logic [31:0] a, b;
    logic [63:0] exp;

    vecs[0] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{3'd0, 32'hFFFF_FFFF, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFFB};
    vecs[2] = '{3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{3'd3, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 32'h7FFF_FFFC};
    vecs[4] = '{3'd3, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF};
    vecs[5] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};

    reset = 1'b0; start = 1'b0; op = '0; rs = '0; rt = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_hilo", {hi, lo}, 64'd0);
    check("reset_busy_done", {62'd0, busy, done}, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Directed vectors with hand-computed results
    for (int i = 0; i < 6; i++) begin
      launch(vecs[i].op, vecs[i].rs, vecs[i].rt);
      wait_done(edges, bc);
      check($sformatf("vec%0d_latency", i), 64'(edges), 64'(W + 1));
      check($sformatf("vec%0d_busy_cycles", i), 64'(bc), 64'(W + 1));
      check($sformatf("vec%0d_hilo", i), {hi, lo}, {vecs[i].hi, vecs[i].lo});
      {hi_m, lo_m} = {vecs[i].hi, vecs[i].lo};
    end

    // done is a single-cycle pulse
    @(posedge clk);
    #1;
    check("done_pulse_width", 64'(done), 64'(0));

    // MTHI while idle: updates on the start edge, no busy, no done
    launch(3'd4, 32'hA5A5_A5A5, 32'd0);
    check("mthi_hi", 64'(hi), 64'h0000_0000_A5A5_A5A5);
    check("mthi_lo_kept", 64'(lo), 64'(lo_m));
    check("mthi_busy_done", {62'd0, busy, done}, 64'd0);
    hi_m = 32'hA5A5_A5A5;

    // MTLO during busy is ignored; the long op still completes
    exp = model(3'd1, 32'h0001_0003, 32'h0002_0007, hi_m, lo_m);
    launch(3'd1, 32'h0001_0003, 32'h0002_0007);
    repeat (2) @(posedge clk);
    launch(3'd5, 32'hDEAD_BEEF, 32'd0);
    check("mtlo_busy_lo_kept", 64'(lo), 64'(lo_m));
    check("mtlo_busy_still_busy", 64'(busy), 64'(1));
    wait_done(edges, bc);
    check("mtlo_busy_completes", 64'(done), 64'(1));
    check("mtlo_busy_result", {hi, lo}, exp);
    {hi_m, lo_m} = exp;

    // Back-to-back: second start lands in the done cycle
    run_long(3'd0, 32'hFFFF_FFF0, 32'h0000_0010, "b2b_first");
    run_long(3'd2, 32'h0000_0064, 32'hFFFF_FFF9, "b2b_second");

    // Asynchronous reset mid-RUN aborts without a result or done
    launch(3'd1, 32'h0000_0003, 32'h0000_0005);
    repeat (10) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("midreset_hilo", {hi, lo}, 64'd0);
    check("midreset_busy", 64'(busy), 64'(0));
    hi_m = '0; lo_m = '0;
    @(negedge clk);
    reset = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) done_seen++;
    end
    check("midreset_no_done", 64'(done_seen), 64'(0));
    run_long(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, "after_reset_mult");

    // Randomized ops against the reference model
    for (int i = 0; i < 24; i++) begin
      o = 3'($urandom_range(0, 6));
      a = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      if (o <= 3'd3) begin
        run_long(o, a, b, $sformatf("rand%0d", i));
      end else begin
        exp = model(o, a, b, hi_m, lo_m);
        launch(o, a, b);
        check($sformatf("rand%0d_short_hilo", i), {hi, lo}, exp);
        check($sformatf("rand%0d_short_busy", i), 64'(busy), 64'(0));
        {hi_m, lo_m} = exp;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
